// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time angle table for the bit-serial CORDIC core.
package cordic_pkg;

    typedef enum logic {CORDIC_ROT = 1'b0, CORDIC_VEC = 1'b1} cordic_mode_e;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} cordic_state_e;

    // atan(1/n) scaled by 2^58, from the alternating Taylor series.
    function automatic longint atan_recip(input longint n);
        longint acc, p, nn;
        acc = 0;
        p   = (longint'(1) <<< 58) / n;
        nn  = n * n;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) acc = acc + p / longint'(2 * k + 1);
            else            acc = acc - p / longint'(2 * k + 1);
            p = p / nn;
        end
        return acc;
    endfunction

    // round(atan(2^-i) * 2^(width-2)); atan(1) = atan(1/2) + atan(1/3) keeps the series fast.
    function automatic longint cordic_atan(input int i, input int width);
        longint v;
        int     sh;
        if (i == 0) v = atan_recip(2) + atan_recip(3);
        else        v = atan_recip(longint'(1) <<< i);
        sh = 58 - (width - 2);
        return (v + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/serial_addsub.sv
// One-bit serial adder/subtractor; the registered carry acts as a borrow when sub=1.
module serial_addsub
    import cordic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic sub,
    input  logic clr,
    output logic s
);

    logic c, c_nxt, a_e;

    assign a_e   = a ^ sub;
    assign s     = a ^ b ^ c;
    assign c_nxt = (a_e & b) | (a_e & c) | (b & c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   c <= 1'b0;
        else if (clr) c <= 1'b0;
        else          c <= c_nxt;
    end

endmodule

// File: rtl/cordic_serial_core.sv
// Bit-serial CORDIC, rotation or vectoring per operation; one bit per clock per coordinate.
module cordic_serial_core
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] z0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    localparam int BW = $clog2(WIDTH);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW = $clog2(ITER + 1);

    function automatic logic [ITER:0][WIDTH-1:0] atan_table();
        logic [ITER:0][WIDTH-1:0] t;
        for (int i = 0; i <= ITER; i++) t[i] = WIDTH'(cordic_atan(i, WIDTH));
        return t;
    endfunction

    localparam logic [ITER:0][WIDTH-1:0] ATAN_TAB = atan_table();

    cordic_state_e    state, state_nxt;
    cordic_mode_e     mode_q;
    logic [BW-1:0]    bit_cnt;
    logic [IW-1:0]    iter;
    logic             sig_pos;
    logic [WIDTH-1:0] wx, wy, wz, ang, rx, ry, rz;
    logic             sx, sy, sz, clr;
    logic [BW-1:0]    sel;
    logic [AW-1:0]    nxt_idx;
    logic             last_bit, last_iter;

    assign sel       = BW'(iter);
    assign nxt_idx   = AW'(iter) + AW'(1);
    assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
    assign last_iter = (iter == IW'(ITER - 1));
    assign clr       = (state != SHIFT);

    // Working registers shift each bit, so bit [sel] of the cross operand is (v >>> iter)[bit].
    serial_addsub u_sx (.clk(clk), .rst_n(rst_n), .a(wx[0]), .b(wy[sel]), .sub(sig_pos),  .clr(clr), .s(sx));
    serial_addsub u_sy (.clk(clk), .rst_n(rst_n), .a(wy[0]), .b(wx[sel]), .sub(~sig_pos), .clr(clr), .s(sy));
    serial_addsub u_sz (.clk(clk), .rst_n(rst_n), .a(wz[0]), .b(ang[0]),  .sub(sig_pos),  .clr(clr), .s(sz));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = last_iter ? DONE : SHIFT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= CORDIC_ROT;
            sig_pos <= 1'b0;
            bit_cnt <= '0;
            iter    <= '0;
            {wx, wy, wz, ang} <= '0;
            {rx, ry, rz}      <= '0;
            {x, y, z}         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wx      <= x0;
                    wy      <= y0;
                    wz      <= z0;
                    ang     <= ATAN_TAB[0];
                    mode_q  <= cordic_mode_e'(mode);
                    sig_pos <= mode ? y0[WIDTH-1] : ~z0[WIDTH-1];
                    bit_cnt <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    wx      <= {wx[WIDTH-1], wx[WIDTH-1:1]};
                    wy      <= {wy[WIDTH-1], wy[WIDTH-1:1]};
                    wz      <= {wz[WIDTH-1], wz[WIDTH-1:1]};
                    ang     <= {1'b0, ang[WIDTH-1:1]};
                    rx      <= {sx, rx[WIDTH-1:1]};
                    ry      <= {sy, ry[WIDTH-1:1]};
                    rz      <= {sz, rz[WIDTH-1:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                end
                LOAD: begin
                    wx      <= rx;
                    wy      <= ry;
                    wz      <= rz;
                    ang     <= ATAN_TAB[nxt_idx];
                    sig_pos <= (mode_q == CORDIC_VEC) ? ry[WIDTH-1] : ~rz[WIDTH-1];
                    bit_cnt <= '0;
                    if (last_iter) begin
                        x <= rx;
                        y <= ry;
                        z <= rz;
                    end else begin
                        iter <= iter + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_serial_core.md
# cordic_serial_core

Parametrised bit-serial CORDIC engine that succeeds the fixed 16-bit rotation-only core. It supports configurable word width and iteration count, and both rotation and vectoring modes selected per operation. It has a start/busy/done handshake and an asynchronous active-low reset. It sits beside the existing datapath as a low-area trig/magnitude unit: one serial add/sub slice per coordinate, processing one bit per clock.

## Interface
- `WIDTH`, default 16: word width of x, y, z (two's complement). Legal range 8..32.
- `ITER`, default 13: number of CORDIC iterations. Legal range 1..WIDTH-1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset. **Asynchronous assert, active-low**; deassertion is synchronised externally.
- `start` in 1: operation request. Sampled only in IDLE.
- `mode` in 1: 0 = rotation, 1 = vectoring. Latched with start.
- `x0`, `y0`, `z0` in WIDTH each: signed operands, latched with start.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when results update.
- `x`, `y`, `z` out WIDTH each: signed results. Held until the next done.

## Operation
- **Number formats**
  - x and y use any common fixed-point format.
  - z is Q2.(WIDTH-2) radians, so pi/4 = round(0.7854·2^(WIDTH-2)); for WIDTH=16 this is 12868.
- **Iteration i**, for i = 0..ITER-1:
  - x' = x − σ·(y>>>i)
  - y' = y + σ·(x>>>i)
  - z' = z − σ·atan_i
  - atan_i = round(atan(2^-i)·2^(WIDTH-2)).
- **Direction σ**, fixed for the whole iteration and taken at iteration start:
  - rotation: σ = +1 when z ≥ 0, else −1.
  - vectoring: σ = +1 when y < 0, else −1.
- **Gain**: none applied. Results carry gain K ≈ 1.6468 for large ITER.
- **Overflow**: arithmetic is modular two's complement with no saturation. The caller keeps |x|,|y|·K below 2^(WIDTH-1).
- **Bit-serial datapath**
  - Working registers shift right arithmetically by one each SHIFT cycle (sign extends).
  - The cross operand bit is taken at index i of the working register, which yields the >>>i term.
  - The angle register shifts in step with the working registers.
  - Result bits enter the result shift registers at the MSB.
- **State machine**
  - IDLE: start=1 → latch operands, mode and σ0; clear carries; iter=0, bit=0; go to SHIFT.
  - SHIFT: one result bit per cycle. After bit WIDTH-1, go to LOAD.
  - LOAD: copy results into the working registers; load atan_{iter+1}; clear carries; compute σ from the new z (rotation) or the new y (vectoring).
    - If iter = ITER-1: update outputs and go to DONE.
    - Otherwise iter++ and go to SHIFT.
  - DONE: done=1 for one cycle, then IDLE.
- **Boundary rules**
  - start while busy is ignored.
  - start during the DONE cycle is ignored; re-issue it in IDLE.
  - z0 = 0 in rotation counts as z ≥ 0, so σ0 = +1.
  - y0 = 0 in vectoring gives σ0 = −1.
- **Reset** (any time, including mid-operation): state=IDLE; busy=0, done=0; x=y=z=0; carries, counters and working registers = 0.

## Timing
- Start is accepted at edge E0.
- busy is high from E0 through the edge that enters DONE.
- Outputs update and done rises at edge E0 + ITER·(WIDTH+1). For WIDTH=16, ITER=13 this is 221 cycles.
- Earliest next start is accepted 2 cycles after done rises.
- Throughput: one result per ITER·(WIDTH+1)+2 cycles.
- Carry registers are updated every SHIFT cycle and cleared on LOAD and on start.

## Structure
- Package `cordic_pkg` holds:
  - the mode enum `CORDIC_ROT`/`CORDIC_VEC`;
  - the state enum `IDLE`/`SHIFT`/`LOAD`/`DONE`;
  - elaboration-time function `cordic_atan(i, WIDTH)`, which builds the angle table as constants.
- Counter widths are $clog2(WIDTH) and $clog2(ITER).
- Sub-module `serial_addsub`, instantiated three times:
  - one-bit full adder/subtractor with registered carry (borrow in subtract mode);
  - inputs a, b, sub, clr;
  - asynchronous clear on rst_n, synchronous clear on clr.

## Test plan
All cases use WIDTH=16, ITER=13 unless stated.
- **Rotation, pi/4:** x0=9949, y0=0, z0=12868 → done at +221 cycles; x≈y≈11585 ±4; |z| ≤ 4.
- **Vectoring:** x0=8192, y0=8192, z0=0 → x≈19078 ±6; |y| ≤ 4; z≈12868 ±4.
- **Rotation, zero angle:** x0=9949, y0=0, z0=0 → x≈16384 ±4; |y| ≤ 4.
- **Handshake:** start pulsed at cycles 5 and 100 of one operation → single done; busy never drops early; outputs unchanged until done.
- **Reset mid-operation:** rst_n low at cycle 110 → busy=0, done=0, x=y=z=0 immediately. A fresh start afterwards gives results identical to the undisturbed run.
- **Parameter sweep:** WIDTH=8, ITER=6 and WIDTH=24, ITER=20 with random in-range operands → done at ITER·(WIDTH+1); results match a bit-accurate model exactly.
